// File: rtl/nms_scan_ctrl_if.sv
// Score-memory side of the NMS scan controller: reference address and
// neighbour select out, score read data back one cycle later.
interface nms_scan_ctrl_if #(
    parameter int SCORE_W = 8
);
    logic [14:0]        ref_addr;
    logic [3:0]         adj_num;
    logic [SCORE_W-1:0] score_rdata;

    modport master (
        output ref_addr,
        output adj_num,
        input  score_rdata
    );

    modport slave (
        input  ref_addr,
        input  adj_num,
        output score_rdata
    );
endinterface

// File: rtl/nms_scan_ctrl.sv
// FAST-9 non-maximum suppression scan controller.
// Define NMS_EARLY_EXIT_EN to abandon a centre as soon as its outcome is known.
module nms_scan_ctrl #(
    parameter int COLUMNS = 180,
    parameter int ROWS    = 120,
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    nms_scan_ctrl_if.master    mem,
    output logic               busy,
    output logic               done,
    output logic               kp_valid,
    output logic [14:0]        kp_addr,
    output logic [SCORE_W-1:0] kp_score
);
    localparam int CW = $clog2(COLUMNS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLUMNS - 2);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 2);
    localparam logic [14:0]   REF_OFS  = 15'(COLUMNS + 2);
    localparam logic [14:0]   FIRST    = 15'(COLUMNS + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, NEXT, DONE} state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic [14:0]        centre;
    logic [3:0]         cnt;
    logic [SCORE_W-1:0] ctr_score;
    logic               max_ok;
    // p1: read presented on the bus, p2: its data is on score_rdata
    logic               p1_vld;
    logic               p2_vld;
    logic [3:0]         p2_adj;

    logic issue;
    logic adv;
    logic wrap;
    logic last;
    logic ctr_zero;
    logic nbr_fail;
    logic early;
    logic emit;

    // Classify the returning read and decide issue/advance for this cycle.
    always_comb begin
        ctr_zero = p2_vld && (p2_adj == 4'd0) && (mem.score_rdata == '0);
        nbr_fail = p2_vld && (p2_adj != 4'd0) && (mem.score_rdata >= ctr_score);
`ifdef NMS_EARLY_EXIT_EN
        early = ((state == ISSUE) || (state == DRAIN)) && (ctr_zero || nbr_fail);
`else
        early = 1'b0;
`endif
        issue = (state == ISSUE) && !early;
        adv   = (state == NEXT) || early;
        emit  = (state == NEXT) && max_ok && !nbr_fail;
        wrap  = (col == COL_LAST);
        last  = wrap && (row == ROW_LAST);
    end

    // Next-state logic; an advancing cycle always moves to the next centre.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = ISSUE;
            ISSUE:   if (cnt == 4'd8) state_nx = DRAIN;
            DRAIN:   state_nx = NEXT;
            NEXT:    state_nx = ISSUE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (adv) state_nx = last ? DONE : ISSUE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Scan position, read pipeline tags and the running maximum test.
    always_ff @(posedge clk) begin
        if (reset) begin
            row       <= '0;
            col       <= '0;
            centre    <= '0;
            cnt       <= '0;
            ctr_score <= '0;
            max_ok    <= 1'b0;
            p1_vld    <= 1'b0;
            p2_vld    <= 1'b0;
            p2_adj    <= '0;
        end else begin
            p1_vld <= issue;
            p2_vld <= p1_vld && !early;
            p2_adj <= mem.adj_num;
            if (state == IDLE) begin
                row    <= RW'(1);
                col    <= CW'(1);
                centre <= FIRST;
                cnt    <= '0;
            end
            if (issue) cnt <= cnt + 4'd1;
            if (adv) begin
                cnt <= '0;
                if (wrap) begin
                    col    <= CW'(1);
                    row    <= row + RW'(1);
                    centre <= centre + 15'd3;
                end else begin
                    col    <= col + CW'(1);
                    centre <= centre + 15'd1;
                end
            end
            if (p2_vld && (p2_adj == 4'd0)) begin
                ctr_score <= mem.score_rdata;
                max_ok    <= !ctr_zero;
            end else if (nbr_fail) begin
                max_ok <= 1'b0;
            end
        end
    end

    // Registered outputs: memory request, status and keypoint strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem.ref_addr <= '0;
            mem.adj_num  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            kp_valid     <= 1'b0;
            kp_addr      <= '0;
            kp_score     <= '0;
        end else begin
            if (issue) begin
                mem.ref_addr <= centre + REF_OFS;
                mem.adj_num  <= cnt;
            end else if ((state == IDLE) || (state == DONE)) begin
                mem.ref_addr <= '0;
                mem.adj_num  <= '0;
            end
            busy     <= (state_nx != IDLE) || (state == DONE);
            done     <= (state == DONE);
            kp_valid <= emit;
            kp_addr  <= emit ? centre : '0;
            kp_score <= emit ? ctr_score : '0;
        end
    end
endmodule

// File: tb/tb_nms_scan_ctrl.sv
// Scoreboard bench for nms_scan_ctrl on a reduced frame.
// Expected keypoints come from a direct local-maximum search over the map.
`timescale 1ns/1ps
module tb_nms_scan_ctrl;
    localparam int C = 24;
    localparam int R = 10;
    localparam int N = (C - 2) * (R - 2);
`ifdef NMS_EARLY_EXIT_EN
    localparam int FRAME_LEN = 3 * N + 2;
`else
    localparam int FRAME_LEN = 11 * N + 2;
`endif
    localparam int LIMIT = 11 * N + 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        kp_valid;
    logic [14:0] kp_addr;
    logic [7:0]  kp_score;

    nms_scan_ctrl_if #(.SCORE_W(8)) mem_if ();

    nms_scan_ctrl #(.COLUMNS(C), .ROWS(R), .SCORE_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mem      (mem_if),
        .busy     (busy),
        .done     (done),
        .kp_valid (kp_valid),
        .kp_addr  (kp_addr),
        .kp_score (kp_score)
    );

    always #5 clk = ~clk;

    logic [7:0]  smem [C*R];
    int          exp_addr [$];
    int          exp_score [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          a0_cyc = 0;
    logic [14:0] prev_ref = '0;
    int          rd_a;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic int nb_off(input logic [3:0] adj);
        case (adj)
            4'd1:    return -C - 1;
            4'd2:    return -C;
            4'd3:    return -C + 1;
            4'd4:    return -1;
            4'd5:    return 1;
            4'd6:    return C - 1;
            4'd7:    return C;
            4'd8:    return C + 1;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Address calculator plus synchronous score memory.
    always @(posedge clk) begin
        rd_a = int'(mem_if.ref_addr) - (C + 2) + nb_off(mem_if.adj_num);
        if (rd_a >= 0 && rd_a < C * R) mem_if.score_rdata <= smem[rd_a];
        else                           mem_if.score_rdata <= '0;
    end

    // Monitor: pop expected keypoints as the DUT strobes them.
    always @(negedge clk) begin
        if (mem_if.adj_num == 4'd0 && mem_if.ref_addr != prev_ref) a0_cyc = cyc;
        prev_ref = mem_if.ref_addr;
        if (kp_valid) begin
            chk("kp_not_with_done", 64'(done), 64'd0);
            if (exp_addr.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL kp_unexpected: got addr %0d score %0d, required no keypoint",
                         kp_addr, kp_score);
            end else begin
                chk("kp_addr", 64'(kp_addr), 64'(exp_addr.pop_front()));
                chk("kp_score", 64'(kp_score), 64'(exp_score.pop_front()));
                chk("kp_latency", 64'(cyc - a0_cyc), 64'd10);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_at_done", 64'(busy), 64'd1);
        end
    end

    task automatic build_expect();
        int v;
        bit is_max;
        exp_addr.delete();
        exp_score.delete();
        for (int r = 1; r < R - 1; r++) begin
            for (int c = 1; c < C - 1; c++) begin
                v = int'(smem[r*C+c]);
                is_max = (v != 0);
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && int'(smem[(r+dr)*C+c+dc]) >= v)
                            is_max = 1'b0;
                if (is_max) begin
                    exp_addr.push_back(r * C + c);
                    exp_score.push_back(v);
                end
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < C * R; i++) smem[i] = '0;
    endtask

    task automatic run_frame(input int exp_len, input bit poke);
        int s;
        int d0;
        int waited;
        build_expect();
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        waited = 0;
        while (done_cnt == d0 && waited < LIMIT) begin
            @(posedge clk); #1;
            waited++;
            start = poke && (cyc - s == 10 || cyc - s == 500);
        end
        start = 1'b0;
        if (done_cnt == d0) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: no done within %0d cycles", LIMIT);
        end else if (exp_len > 0) begin
            chk("frame_len", 64'(done_cyc - s), 64'(exp_len));
        end
        chk("kp_missing", 64'(exp_addr.size()), 64'd0);
        exp_addr.delete();
        exp_score.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        int waited;
        int d0;
        clear_mem();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ref_addr", 64'(mem_if.ref_addr), 64'd0);
        chk("rst_adj_num", 64'(mem_if.adj_num), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_kp_valid", 64'(kp_valid), 64'd0);
        chk("rst_kp_addr", 64'(kp_addr), 64'd0);
        chk("rst_kp_score", 64'(kp_score), 64'd0);
        reset = 1'b0;

        run_frame(FRAME_LEN, 1'b0);
        run_frame(FRAME_LEN, 1'b1);

        smem[C+1] = 8'd5;
        run_frame(0, 1'b0);

        clear_mem();
        smem[3*C+5] = 8'd7;
        smem[3*C+6] = 8'd7;
        run_frame(0, 1'b0);
        smem[3*C+6] = 8'd6;
        run_frame(0, 1'b0);

        clear_mem();
        smem[0] = 8'd200;
        smem[C-1] = 8'd200;
        smem[(R-1)*C+3] = 8'd50;
        smem[C*R-1] = 8'd9;
        run_frame(0, 1'b0);

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < C * R; i++) begin
                if (f < 2) smem[i] = 8'($urandom_range(0, 255));
                else       smem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 4)) : 8'd0;
            end
            run_frame(0, 1'b0);
        end

        clear_mem();
        smem[C+1] = 8'd5;
        exp_addr.delete();
        exp_score.delete();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waited = 0;
        while (!(mem_if.adj_num == 4'd4 && mem_if.ref_addr == 15'(2 * C + 3)) && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("mid_pixel_reached", 64'(waited < 100), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_ref_addr", 64'(mem_if.ref_addr), 64'd0);
        chk("mrst_adj_num", 64'(mem_if.adj_num), 64'd0);
        chk("mrst_kp_valid", 64'(kp_valid), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_kp_addr", 64'(kp_addr), 64'd0);
        chk("mrst_kp_score", 64'(kp_score), 64'd0);
        d0 = done_cnt;
        repeat (30) @(posedge clk);
        #1;
        chk("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        chk("idle_after_reset", 64'(busy), 64'd0);
        run_frame(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
